stage_mem: RTL and testbench
============================

Name: stage_mem

Overview:
Memory-access pipeline stage directly downstream of the execute stage. Consumes the EX/MEM pipeline register: ALU result, store data, zero flag, control bits, destination register and branch target. Performs the data-bus load/store with a req/ack handshake, stalls the upstream pipeline on wait states, and times out hung accesses. Resolves branch/jump redirects for fetch and registers results into the MEM/WB pipeline register.

Parameters:
DATA_DBUS_WIDTH, 32, data bus and register data width
ADDR_DBUS_WIDTH, 32, data bus address width (low bits of i_AluOut)
ADDR_IBUS_WIDTH, 32, instruction address width (PC target)
TIMEOUT_CYCLES, 255, max wait cycles before bus error; 0 disables the timeout

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  EX/MEM register holds a real instruction (0 = bubble)
i_AluOut  in  DATA_DBUS_WIDTH  ALU result / memory address
i_WriteData  in  DATA_DBUS_WIDTH  store data
i_zero  in  1  ALU zero flag
i_reg_we  in  1  register-file write enable
i_MemWriteEnable  in  1  store
i_MemToReg  in  1  load (WB selects memory data)
i_WriteReg  in  5  destination register
i_pc_wdata  in  ADDR_IBUS_WIDTH  branch/jump target
i_Branch  in  1  conditional branch
i_Jump  in  1  unconditional jump
o_dbus_addr  out  ADDR_DBUS_WIDTH  bus address = i_AluOut[ADDR_DBUS_WIDTH-1:0]
o_dbus_wdata  out  DATA_DBUS_WIDTH  = i_WriteData
o_dbus_we  out  1  = i_MemWriteEnable
o_dbus_req  out  1  access request
i_dbus_rdata  in  DATA_DBUS_WIDTH  read data, valid with ack
i_dbus_ack  in  1  access complete
o_stall  out  1  upstream stages must hold their registers
o_bus_error  out  1  sticky timeout flag
o_pc_sel  out  1  fetch must load o_pc_wdata
o_pc_wdata  out  ADDR_IBUS_WIDTH  redirect target
o_valid  out  1  MEM/WB valid
o_ReadData  out  DATA_DBUS_WIDTH  loaded data
o_AluOut  out  DATA_DBUS_WIDTH  forwarded ALU result
o_reg_we  out  1  forwarded write enable, gated by valid
o_MemToReg  out  1  forwarded
o_WriteReg  out  5  forwarded

Behaviour:
- access = i_valid & (i_MemWriteEnable | i_MemToReg). Both set: write performed, read data also captured.
- FSM states MEM_IDLE, MEM_WAIT, MEM_ERROR; timeout counter cnt.
- MEM_IDLE: o_dbus_req = access (combinational). access & i_dbus_ack -> zero-wait completion, stay IDLE, no stall. access & ~i_dbus_ack -> MEM_WAIT, cnt <= 1.
- MEM_WAIT: o_dbus_req = 1; bus outputs come from held inputs, stable because upstream is stalled. i_dbus_ack -> MEM_IDLE, cnt <= 0. Else if TIMEOUT_CYCLES != 0 and cnt == TIMEOUT_CYCLES -> MEM_ERROR. Else cnt <= cnt+1. Ack on the same cycle cnt reaches the limit: ack wins.
- MEM_ERROR: o_dbus_req = 0, o_stall = 1, o_bus_error = 1; left only by reset.
- o_stall = (IDLE|WAIT) & access & ~i_dbus_ack, or state == ERROR. Combinational.
- i_dbus_ack while o_dbus_req = 0 is ignored.
- MEM/WB register updates every cycle:
  - o_stall = 1: o_valid <= 0 and o_reg_we <= 0 (bubble); the other outputs hold.
  - o_stall = 0: o_valid <= i_valid; o_reg_we <= i_reg_we & i_valid; o_AluOut, o_MemToReg, o_WriteReg <= inputs; o_ReadData <= i_dbus_rdata if a load completes this cycle, else hold.
- Latency: one cycle from EX/MEM to MEM/WB with zero-wait memory; N wait cycles add N cycles.
- Redirect, combinational: o_pc_sel = i_valid & (i_Jump | (i_Branch & i_zero)) & (state != ERROR); o_pc_wdata = i_pc_wdata.
- Reset: state MEM_IDLE, cnt 0, all registered outputs 0. o_dbus_req, o_stall and o_pc_sel are forced 0 while i_rst = 1, including reset during MEM_WAIT.
- cnt width: $clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- Add enum MemState {MEM_IDLE, MEM_WAIT, MEM_ERROR} to the shared types package.
- FSM and counter stay inline; no sub-module is warranted.

Test Plan:
1. Load, addr 0x100, ack in same cycle, rdata 0xDEADBEEF -> no stall; next cycle o_ReadData = 0xDEADBEEF, o_valid = 1, o_WriteReg as given.
2. Store addr 0x204 data 0x12345678, ack after 3 cycles -> o_dbus_req held 4 cycles with stable addr/wdata/we = 1; o_stall = 1 for 3 cycles; o_valid = 0 during the stall, then 1.
3. TIMEOUT_CYCLES = 4, load, never ack -> MEM_ERROR after 4 wait cycles; o_bus_error = 1 sticky, o_stall = 1, req = 0; cleared only by i_rst.
4. Ack arrives on the cycle cnt == TIMEOUT_CYCLES -> access completes, no error.
5. Branch with i_zero = 1, target 0x40 -> o_pc_sel = 1, o_pc_wdata = 0x40 in the same cycle; same with i_zero = 0 -> o_pc_sel = 0; i_Jump = 1 -> o_pc_sel = 1.
6. Assert i_rst during MEM_WAIT -> req, stall and o_pc_sel drop that cycle; all outputs 0 next cycle; a late ack is ignored.

Source files
------------

// File: rtl/stage_mem_pkg.sv
// Shared types for the memory-access pipeline stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package stage_mem_pkg;

   // Bus access sequencer states
   typedef enum logic [1:0] {
      MEM_IDLE  = 2'd0,
      MEM_WAIT  = 2'd1,
      MEM_ERROR = 2'd2
   } MemState;

   // Width of a counter that must reach max_val; never below one bit
   function automatic int cnt_width(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/stage_mem.sv
// MEM stage: data-bus load/store with req/ack, branch/jump redirect, MEM/WB register.
// Latency: 1 cycle EX/MEM -> MEM/WB with zero-wait memory, +1 cycle per bus wait state.
// Backpressure: o_stall holds upstream while an access is pending; a hung access locks in MEM_ERROR.
module stage_mem
   import stage_mem_pkg::*;
#(
   parameter int unsigned DATA_DBUS_WIDTH = 32,
   parameter int unsigned ADDR_DBUS_WIDTH = 32,
   parameter int unsigned ADDR_IBUS_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES  = 255
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_valid,
   input  logic [DATA_DBUS_WIDTH-1:0] i_AluOut,
   input  logic [DATA_DBUS_WIDTH-1:0] i_WriteData,
   input  logic                       i_zero,
   input  logic                       i_reg_we,
   input  logic                       i_MemWriteEnable,
   input  logic                       i_MemToReg,
   input  logic [4:0]                 i_WriteReg,
   input  logic [ADDR_IBUS_WIDTH-1:0] i_pc_wdata,
   input  logic                       i_Branch,
   input  logic                       i_Jump,
   output logic [ADDR_DBUS_WIDTH-1:0] o_dbus_addr,
   output logic [DATA_DBUS_WIDTH-1:0] o_dbus_wdata,
   output logic                       o_dbus_we,
   output logic                       o_dbus_req,
   input  logic [DATA_DBUS_WIDTH-1:0] i_dbus_rdata,
   input  logic                       i_dbus_ack,
   output logic                       o_stall,
   output logic                       o_bus_error,
   output logic                       o_pc_sel,
   output logic [ADDR_IBUS_WIDTH-1:0] o_pc_wdata,
   output logic                       o_valid,
   output logic [DATA_DBUS_WIDTH-1:0] o_ReadData,
   output logic [DATA_DBUS_WIDTH-1:0] o_AluOut,
   output logic                       o_reg_we,
   output logic                       o_MemToReg,
   output logic [4:0]                 o_WriteReg
);

   localparam int CNT_W = cnt_width(int'(TIMEOUT_CYCLES));
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   MemState          state;
   logic [CNT_W-1:0] cnt;
   logic             access;
   logic             load_done;

   assign access = i_valid & (i_MemWriteEnable | i_MemToReg);

   // Bus outputs follow the EX/MEM register; it is frozen while we stall
   assign o_dbus_addr  = i_AluOut[ADDR_DBUS_WIDTH-1:0];
   assign o_dbus_wdata = i_WriteData;
   assign o_dbus_we    = i_MemWriteEnable;
   assign o_pc_wdata   = i_pc_wdata;
   assign o_bus_error  = (state == MEM_ERROR);

   // Request, stall and redirect decode; all forced low while in reset
   always_comb begin
      o_dbus_req = 1'b0;
      o_stall    = 1'b0;
      o_pc_sel   = 1'b0;
      if (!i_rst) begin
         o_pc_sel = i_valid & (i_Jump | (i_Branch & i_zero)) & (state != MEM_ERROR);
         unique case (state)
            MEM_IDLE: begin
               o_dbus_req = access;
               o_stall    = access & ~i_dbus_ack;
            end
            MEM_WAIT: begin
               o_dbus_req = 1'b1;
               o_stall    = access & ~i_dbus_ack;
            end
            MEM_ERROR: o_stall = 1'b1;
            default: ;
         endcase
      end
   end

   // An ack only counts while a request is driven, so stray acks are ignored
   assign load_done = o_dbus_req & i_dbus_ack & i_MemToReg;

   // Access sequencer with wait-state timeout; ack beats timeout on the same cycle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= MEM_IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            MEM_IDLE: begin
               if (access && !i_dbus_ack) begin
                  state <= MEM_WAIT;
                  cnt   <= CNT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (i_dbus_ack) begin
                  state <= MEM_IDLE;
                  cnt   <= '0;
               end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_MAX)) begin
                  state <= MEM_ERROR;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            MEM_ERROR: state <= MEM_ERROR;
            default: begin
               state <= MEM_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // MEM/WB register: bubble while stalled, otherwise capture the EX/MEM contents
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid    <= 1'b0;
         o_reg_we   <= 1'b0;
         o_ReadData <= '0;
         o_AluOut   <= '0;
         o_MemToReg <= 1'b0;
         o_WriteReg <= '0;
      end else if (o_stall) begin
         o_valid  <= 1'b0;
         o_reg_we <= 1'b0;
      end else begin
         o_valid    <= i_valid;
         o_reg_we   <= i_reg_we & i_valid;
         o_AluOut   <= i_AluOut;
         o_MemToReg <= i_MemToReg;
         o_WriteReg <= i_WriteReg;
         if (load_done) o_ReadData <= i_dbus_rdata;
      end
   end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem with a short timeout so the error path is reachable.
// Latency: drives one EX/MEM entry at a time and checks MEM/WB one cycle after completion.
// Backpressure: the bench plays the bus slave, inserting a chosen number of wait states.
module tb_stage_mem;

   localparam int TO = 4;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic [31:0] i_AluOut = '0;
   logic [31:0] i_WriteData = '0;
   logic        i_zero = 1'b0;
   logic        i_reg_we = 1'b0;
   logic        i_MemWriteEnable = 1'b0;
   logic        i_MemToReg = 1'b0;
   logic [4:0]  i_WriteReg = '0;
   logic [31:0] i_pc_wdata = '0;
   logic        i_Branch = 1'b0;
   logic        i_Jump = 1'b0;
   logic [31:0] i_dbus_rdata = '0;
   logic        i_dbus_ack = 1'b0;
   logic [31:0] o_dbus_addr, o_dbus_wdata, o_pc_wdata, o_ReadData, o_AluOut;
   logic        o_dbus_we, o_dbus_req, o_stall, o_bus_error, o_pc_sel;
   logic        o_valid, o_reg_we, o_MemToReg;
   logic [4:0]  o_WriteReg;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] m_rdata = '0;   // last loaded value the MEM/WB register should show

   stage_mem #(
      .DATA_DBUS_WIDTH(32), .ADDR_DBUS_WIDTH(32), .ADDR_IBUS_WIDTH(32), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_AluOut(i_AluOut),
      .i_WriteData(i_WriteData), .i_zero(i_zero), .i_reg_we(i_reg_we),
      .i_MemWriteEnable(i_MemWriteEnable), .i_MemToReg(i_MemToReg), .i_WriteReg(i_WriteReg),
      .i_pc_wdata(i_pc_wdata), .i_Branch(i_Branch), .i_Jump(i_Jump),
      .o_dbus_addr(o_dbus_addr), .o_dbus_wdata(o_dbus_wdata), .o_dbus_we(o_dbus_we),
      .o_dbus_req(o_dbus_req), .i_dbus_rdata(i_dbus_rdata), .i_dbus_ack(i_dbus_ack),
      .o_stall(o_stall), .o_bus_error(o_bus_error), .o_pc_sel(o_pc_sel), .o_pc_wdata(o_pc_wdata),
      .o_valid(o_valid), .o_ReadData(o_ReadData), .o_AluOut(o_AluOut), .o_reg_we(o_reg_we),
      .o_MemToReg(o_MemToReg), .o_WriteReg(o_WriteReg)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic we, input logic rd, input logic rwe,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
      i_valid = v; i_MemWriteEnable = we; i_MemToReg = rd; i_reg_we = rwe;
      i_AluOut = alu; i_WriteData = wd; i_WriteReg = wr;
      i_Branch = 1'b0; i_Jump = 1'b0; i_zero = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      set_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 5'd3);
      i_Jump = 1'b1;
      #1;
      n_checks++; if (o_dbus_req !== 1'b0 || o_stall !== 1'b0 || o_pc_sel !== 1'b0)
         $display("FAIL reset_comb req=%b stall=%b pc_sel=%b required 0/0/0", o_dbus_req, o_stall, o_pc_sel);
         else n_pass++;
      tick(); tick();
      n_checks++; if ({o_valid, o_reg_we, o_MemToReg, o_bus_error} !== 4'b0 || o_ReadData !== 32'h0
                      || o_AluOut !== 32'h0 || o_WriteReg !== 5'd0)
         $display("FAIL reset_regs valid=%b we=%b m2r=%b err=%b rdata=%h alu=%h wr=%0d required all 0",
                  o_valid, o_reg_we, o_MemToReg, o_bus_error, o_ReadData, o_AluOut, o_WriteReg);
         else n_pass++;
      set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      i_rst = 1'b0;
      m_rdata = '0;
      tick();
   endtask

   task automatic test_zero_wait_load();
      set_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd7);
      i_dbus_ack = 1'b1; i_dbus_rdata = 32'hDEADBEEF;
      #1;
      n_checks++; if (o_dbus_req !== 1'b1 || o_stall !== 1'b0 || o_dbus_addr !== 32'h100)
         $display("FAIL zw_load_bus req=%b stall=%b addr=%h required 1/0/00000100", o_dbus_req, o_stall, o_dbus_addr);
         else n_pass++;
      tick();
      m_rdata = 32'hDEADBEEF;
      i_dbus_ack = 1'b0; set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      n_checks++; if (o_ReadData !== 32'hDEADBEEF || o_valid !== 1'b1 || o_WriteReg !== 5'd7 || o_reg_we !== 1'b1)
         $display("FAIL zw_load_wb rdata=%h valid=%b wr=%0d we=%b required deadbeef/1/7/1",
                  o_ReadData, o_valid, o_WriteReg, o_reg_we);
         else n_pass++;
   endtask

   task automatic test_store_wait();
      set_ex(1'b1, 1'b1, 1'b0, 1'b0, 32'h204, 32'h12345678, 5'd0);
      for (int c = 0; c <= 3; c++) begin
         i_dbus_ack = (c == 3);
         i_dbus_rdata = 32'hA5A5_0000 + 32'(c);
         #1;
         n_checks++; if (o_dbus_req !== 1'b1 || o_dbus_addr !== 32'h204 || o_dbus_wdata !== 32'h12345678
                         || o_dbus_we !== 1'b1 || o_stall !== (c < 3))
            $display("FAIL store_cycle%0d req=%b addr=%h wdata=%h we=%b stall=%b required 1/204/12345678/1/%b",
                     c, o_dbus_req, o_dbus_addr, o_dbus_wdata, o_dbus_we, o_stall, c < 3);
            else n_pass++;
         tick();
         if (c < 3) begin
            n_checks++; if (o_valid !== 1'b0)
               $display("FAIL store_bubble%0d valid=%b required 0", c, o_valid);
               else n_pass++;
         end
      end
      i_dbus_ack = 1'b0; set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      n_checks++; if (o_valid !== 1'b1 || o_reg_we !== 1'b0 || o_ReadData !== m_rdata || o_AluOut !== 32'h204)
         $display("FAIL store_wb valid=%b we=%b rdata=%h alu=%h required 1/0/%h/204",
                  o_valid, o_reg_we, o_ReadData, o_AluOut, m_rdata);
         else n_pass++;
   endtask

   task automatic test_redirect();
      logic [3:0] exp;
      logic [3:0] got;
      set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd1);
      i_pc_wdata = 32'h40;
      i_Branch = 1'b1; i_zero = 1'b1; #1; got[0] = o_pc_sel;
      n_checks++; if (o_pc_wdata !== 32'h40)
         $display("FAIL redirect_target got=%h required 00000040", o_pc_wdata);
         else n_pass++;
      i_zero = 1'b0; #1; got[1] = o_pc_sel;
      i_Branch = 1'b0; i_Jump = 1'b1; #1; got[2] = o_pc_sel;
      i_valid = 1'b0; #1; got[3] = o_pc_sel;
      exp = 4'b0101;
      n_checks++; if (got !== exp)
         $display("FAIL redirect_sel got=%b required %b (bits: bubble-jump,jump,branch-nz,branch-z)", got, exp);
         else n_pass++;
      set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         logic        v, we, rd, rwe, acc, br, jp, z, exp_sel;
         logic [31:0] alu, wd, rdat, tgt;
         logic [4:0]  wr;
         int          kind, nw;
         v    = ($urandom_range(0, 3) != 0);
         kind = $urandom_range(0, 3);
         we   = (kind == 2 || kind == 3);
         rd   = (kind == 1 || kind == 3);
         rwe  = $urandom_range(0, 1);
         alu  = $urandom; wd = $urandom; rdat = $urandom; tgt = $urandom;
         wr   = 5'($urandom_range(0, 31));
         br   = $urandom_range(0, 1); jp = $urandom_range(0, 1); z = $urandom_range(0, 1);
         acc  = v & (we | rd);
         nw   = acc ? $urandom_range(0, 3) : 0;
         exp_sel = v & (jp | (br & z));
         set_ex(v, we, rd, rwe, alu, wd, wr);
         i_Branch = br; i_Jump = jp; i_zero = z; i_pc_wdata = tgt;
         for (int c = 0; c <= nw; c++) begin
            i_dbus_ack   = acc ? (c == nw) : 1'($urandom_range(0, 1));
            i_dbus_rdata = (c == nw) ? rdat : $urandom;
            #1;
            n_checks++; if (o_dbus_req !== acc || o_stall !== (c < nw) || o_pc_sel !== exp_sel
                            || o_pc_wdata !== tgt || (acc && (o_dbus_addr !== alu || o_dbus_we !== we)))
               $display("FAIL rnd%0d_c%0d req=%b stall=%b sel=%b addr=%h required %b/%b/%b/%h",
                        n, c, o_dbus_req, o_stall, o_pc_sel, o_dbus_addr, acc, c < nw, exp_sel, alu);
               else n_pass++;
            tick();
            if (c < nw) begin
               n_checks++; if (o_valid !== 1'b0 || o_reg_we !== 1'b0)
                  $display("FAIL rnd%0d_bubble valid=%b we=%b required 0/0", n, o_valid, o_reg_we);
                  else n_pass++;
            end
         end
         if (acc && rd) m_rdata = rdat;
         n_checks++; if (o_valid !== v || o_reg_we !== (rwe & v) || o_AluOut !== alu
                         || o_WriteReg !== wr || o_MemToReg !== rd || o_ReadData !== m_rdata)
            $display("FAIL rnd%0d_wb valid=%b we=%b alu=%h wr=%0d m2r=%b rdata=%h required %b/%b/%h/%0d/%b/%h",
                     n, o_valid, o_reg_we, o_AluOut, o_WriteReg, o_MemToReg, o_ReadData,
                     v, rwe & v, alu, wr, rd, m_rdata);
            else n_pass++;
      end
      i_dbus_ack = 1'b0; set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      tick();
   endtask

   task automatic test_ack_at_limit();
      set_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h3C0, 32'h0, 5'd9);
      i_dbus_ack = 1'b0;
      // one idle cycle plus waits at cnt 1..3 leaves the counter at the limit
      for (int c = 0; c < TO; c++) tick();
      i_dbus_ack = 1'b1; i_dbus_rdata = 32'hCAFEF00D;
      #1;
      n_checks++; if (o_stall !== 1'b0 || o_dbus_req !== 1'b1)
         $display("FAIL limit_ack stall=%b req=%b required 0/1", o_stall, o_dbus_req);
         else n_pass++;
      tick();
      m_rdata = 32'hCAFEF00D;
      i_dbus_ack = 1'b0; set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      tick();
      n_checks++; if (o_bus_error !== 1'b0 || o_ReadData !== m_rdata || o_stall !== 1'b0)
         $display("FAIL limit_done err=%b rdata=%h stall=%b required 0/%h/0", o_bus_error, o_ReadData, o_stall, m_rdata);
         else n_pass++;
   endtask

   task automatic test_timeout_error();
      set_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 32'h0, 5'd4);
      i_dbus_ack = 1'b0;
      for (int c = 0; c < TO; c++) tick();
      n_checks++; if (o_bus_error !== 1'b0 || o_dbus_req !== 1'b1 || o_stall !== 1'b1)
         $display("FAIL to_last_wait err=%b req=%b stall=%b required 0/1/1", o_bus_error, o_dbus_req, o_stall);
         else n_pass++;
      tick();
      i_Jump = 1'b1;
      for (int c = 0; c < 3; c++) begin
         i_dbus_ack = (c == 1);
         #1;
         n_checks++; if (o_bus_error !== 1'b1 || o_dbus_req !== 1'b0 || o_stall !== 1'b1
                         || o_pc_sel !== 1'b0 || o_valid !== 1'b0)
            $display("FAIL to_error%0d err=%b req=%b stall=%b sel=%b valid=%b required 1/0/1/0/0",
                     c, o_bus_error, o_dbus_req, o_stall, o_pc_sel, o_valid);
            else n_pass++;
         tick();
      end
      i_dbus_ack = 1'b0; set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      m_rdata = '0;
      #1;
      n_checks++; if (o_bus_error !== 1'b0 || o_stall !== 1'b0)
         $display("FAIL to_cleared err=%b stall=%b required 0/0", o_bus_error, o_stall);
         else n_pass++;
      tick();
   endtask

   task automatic test_reset_during_wait();
      set_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h600, 32'h0, 5'd12);
      i_dbus_ack = 1'b0;
      tick();
      i_Jump = 1'b1; i_rst = 1'b1;
      #1;
      n_checks++; if (o_dbus_req !== 1'b0 || o_stall !== 1'b0 || o_pc_sel !== 1'b0)
         $display("FAIL rst_wait_comb req=%b stall=%b sel=%b required 0/0/0", o_dbus_req, o_stall, o_pc_sel);
         else n_pass++;
      i_dbus_ack = 1'b1; i_dbus_rdata = 32'hBADBAD00;
      tick();
      i_rst = 1'b0;
      set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      #1;
      n_checks++; if (o_valid !== 1'b0 || o_ReadData !== 32'h0 || o_AluOut !== 32'h0 || o_WriteReg !== 5'd0
                      || o_bus_error !== 1'b0 || o_dbus_req !== 1'b0)
         $display("FAIL rst_wait_regs valid=%b rdata=%h alu=%h wr=%0d err=%b req=%b required all 0",
                  o_valid, o_ReadData, o_AluOut, o_WriteReg, o_bus_error, o_dbus_req);
         else n_pass++;
      tick();
      n_checks++; if (o_ReadData !== 32'h0 || o_valid !== 1'b0 || o_stall !== 1'b0)
         $display("FAIL late_ack rdata=%h valid=%b stall=%b required 0/0/0", o_ReadData, o_valid, o_stall);
         else n_pass++;
      i_dbus_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_wait_load();
      test_store_wait();
      test_redirect();
      test_random();
      test_ack_at_limit();
      test_timeout_error();
      test_reset_during_wait();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
